// File: rtl/gray_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// gray_frame_ctrl_if
//   Bundles the control, source-read and destination-write signals of the
//   RGB-to-gray frame converter.
//
//   Signals:
//     start     frame request (host -> controller)
//     count     pixels to convert, sampled with start
//     busy      frame in progress
//     done      last frame finished, held until next accepted start or reset
//     rd_en     source SRAM read strobe
//     rd_addr   source SRAM address
//     rd_data   source RGB pixel {R,G,B}, valid one cycle after rd_en
//     wr_en     destination SRAM write strobe
//     wr_addr   destination SRAM address
//     wr_data   gray pixel {Y,Y,Y}
//     wr_ready  destination accepts the write this cycle
//
//   Modports:
//     master    the controller itself
//     slave     host plus the two memories around it
// -----------------------------------------------------------------------------
interface gray_frame_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] count;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [23:0]           rd_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [23:0]           wr_data;
  logic                  wr_ready;

  modport master (
    input  start, count, rd_data, wr_ready,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, count, rd_data, wr_ready,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/gray_frame_ctrl.sv
// -----------------------------------------------------------------------------
// gray_frame_ctrl
//   Walks a frame of up to DEPTH RGB pixels, reading each from a source SRAM,
//   converting it to gray (Y = (R + 2G + B) / 4, replicated into all three
//   channels) and writing it to the same address in a destination SRAM.
//   One pixel takes RD -> CV -> WR, i.e. three cycles when wr_ready is high.
//
//   Ports:
//     clk   single clock, rising edge
//     rst   synchronous active-high reset, wins over everything
//     bus   gray_frame_ctrl_if.master (see interface header)
// -----------------------------------------------------------------------------
module gray_frame_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 600
) (
  input  logic                clk,
  input  logic                rst,
  gray_frame_ctrl_if.master   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] CV   = 2'd2;
  localparam logic [1:0] WR   = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [1:0]            state_q,  state_d;
  logic [ADDR_WIDTH-1:0] index_q,  index_d;
  logic [ADDR_WIDTH-1:0] count_q,  count_d;
  logic [23:0]           result_q, result_d;
  logic                  done_q,   done_d;

  // One extra bit so that index+1 can equal a full DEPTH-sized frame count.
  logic [ADDR_WIDTH:0]   index_inc;

  function automatic logic [7:0] gray_of(input logic [23:0] rgb);
    logic [9:0] sum;
    // 255 + 510 + 255 = 1020 fits in 10 bits, so no overflow handling needed.
    sum = {2'b00, rgb[23:16]} + {1'b0, rgb[15:8], 1'b0} + {2'b00, rgb[7:0]};
    return sum[9:2];
  endfunction

  assign index_inc = {1'b0, index_q} + (ADDR_WIDTH+1)'(1);

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    index_d  = index_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = done_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            // Empty frame: report completion without touching memory.
            done_d = 1'b1;
          end else begin
            state_d = RD;
            index_d = '0;
            count_d = (bus.count > DEPTH_A) ? DEPTH_A : bus.count;
            done_d  = 1'b0;
          end
        end
      end
      RD: state_d = CV;
      CV: begin
        result_d = {3{gray_of(bus.rd_data)}};
        state_d  = WR;
      end
      WR: begin
        if (bus.wr_ready) begin
          if (index_inc == {1'b0, count_q}) begin
            // Last pixel: index stays on the final address so it never
            // steps past DEPTH-1.
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            index_d = index_inc[ADDR_WIDTH-1:0];
            state_d = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      index_q  <= '0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      count_q  <= count_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Strobes decode straight from state; addresses and data come from
  // registers, so reset drives all of them to zero in the same edge.
  assign bus.rd_en   = (state_q == RD);
  assign bus.rd_addr = index_q;
  assign bus.wr_en   = (state_q == WR);
  assign bus.wr_addr = index_q;
  assign bus.wr_data = result_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;

endmodule

// File: doc/gray_frame_ctrl.md
GRAY_FRAME_CTRL -- requirements
Module: gray_frame_ctrl

Interface
REQ-001: Parameter ADDR_WIDTH, default 10, SHALL set the address width of both memory ports.
REQ-002: Parameter DEPTH, default 600, SHALL set the maximum number of pixels per frame.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005: start  input  1  SHALL request a frame conversion; sampled only in IDLE.
REQ-006: count  input  ADDR_WIDTH  SHALL give the number of pixels to convert; sampled with start.
REQ-007: rd_en  output  1  SHALL be the read strobe to the source pixel SRAM.
REQ-008: rd_addr  output  ADDR_WIDTH  SHALL be the source pixel address.
REQ-009: rd_data  input  24  SHALL be the source RGB pixel {R[23:16],G[15:8],B[7:0]}, valid one cycle after rd_en.
REQ-010: wr_en  output  1  SHALL be the write strobe to the destination SRAM.
REQ-011: wr_addr  output  ADDR_WIDTH  SHALL be the destination address.
REQ-012: wr_data  output  24  SHALL be the converted gray pixel.
REQ-013: wr_ready  input  1  SHALL indicate the destination accepts the write this cycle.
REQ-014: busy  output  1  SHALL be high while a frame is in progress.
REQ-015: done  output  1  SHALL be high once a frame completes, held until the next accepted start or reset.

Function
REQ-016: FSM SHALL have states IDLE, RD, CV, WR.
REQ-017: IDLE: start=1 with count>0 -> RD; index<=0, latched count<=min(count,DEPTH), done<=0.
REQ-018: IDLE: start=1 with count=0 -> stay IDLE, done<=1, no memory access.
REQ-019: RD: rd_en=1, rd_addr=index; next state CV unconditionally.
REQ-020: CV: result<=gray(rd_data); next state WR.
REQ-021: gray: sum = R + 2*G + B computed at 10 bits (max 1020, no overflow); y = sum>>2 (8 bits); result = {y,y,y}.
REQ-022: WR: wr_en=1, wr_addr=index, wr_data=result, all held stable while wr_ready=0.
REQ-023: WR with wr_ready=1: index<=index+1; if index+1 = latched count -> IDLE with done<=1, else -> RD.
REQ-024: rd_en SHALL be 0 outside RD; wr_en SHALL be 0 outside WR.
REQ-025: busy SHALL be 1 exactly when state is not IDLE.
REQ-026: start while busy SHALL be ignored; count changes while busy SHALL have no effect.
REQ-027: Latency with wr_ready tied high: 3 cycles per pixel; done rises after edge 3N when start is sampled at edge 0.
REQ-028: Index SHALL never exceed DEPTH-1; count>DEPTH SHALL be clamped to DEPTH.

Reset
REQ-029: rst=1 at a clock edge SHALL force state IDLE, index=0, result=0, done=0, busy=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0.
REQ-030: rst SHALL take priority over start and wr_ready, including mid-frame; an interrupted frame is abandoned, not resumed.

Verification
REQ-031: count=1, wr_ready=1, rd_data=0x102030 -> wr_data=0x202020 at wr_addr=0; done=1 after edge 3.
REQ-032: count=4, wr_ready=1, rd_data=0xFFFFFF -> four writes of 0xFFFFFF to addresses 0..3; busy=1 for 12 cycles; done=1 after edge 12.
REQ-033: count=2, wr_ready low 5 cycles in first WR -> wr_en/wr_addr=0/wr_data held for 6 cycles; no rd_en during stall; done after edge 11.
REQ-034: count=0 with start -> no rd_en/wr_en; done=1 after edge 1; busy stays 0.
REQ-035: rst asserted in CV of pixel 2 of count=5 -> all outputs reset next edge; new start with count=1 converts address 0 normally.
REQ-036: count=700 (DEPTH=600) -> exactly 600 writes, last wr_addr=599; second start while busy ignored.
